fetch_unit: RTL and testbench

//  Instruction fetch stage directly downstream of the PC register. Takes the current PC,

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: word size, FSM states and queue entry layout.
package fetch_pkg;
  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] instr;
  } fetch_entry_t;

  function automatic logic [WORD_SIZE-1:0] word_align(input logic [WORD_SIZE-1:0] addr);
    return {addr[WORD_SIZE-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with registered head; push and pop may coincide at any occupancy.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: credit-limited word requests to imem, in-order response queue to decode,
// flush by dropping outstanding responses, halt by withholding new requests.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt,
  input  logic                 flush,
  input  logic [WORD_SIZE-1:0] pc_i,
  output logic                 pc_advance,
  output logic                 imem_req,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [WORD_SIZE-1:0] imem_rdata,
  output logic                 id_valid,
  output logic [WORD_SIZE-1:0] id_instr,
  output logic [WORD_SIZE-1:0] id_pc,
  input  logic                 id_ready,
  output logic [CNT_W-1:0]     fetch_count,
  output fetch_state_t         state_dbg
);
  localparam int CW = $clog2(DEPTH + 1);

  // Handshakes: a transfer happens in a cycle where both sides are high (imem_req & imem_gnt,
  // id_valid & id_ready); valid never waits on ready, ready may depend on valid.
  fetch_state_t state, state_next;
  logic [CW-1:0] in_flight, q_count, drop, in_flight_next;
  logic [CW:0]   occupancy;
  logic          pf_full, pf_empty, q_full, q_empty;
  logic          drop_hit, q_push, q_pop;
  logic [WORD_SIZE-1:0] rsp_pc;
  fetch_entry_t  q_din, q_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = RUN;
      RUN:     if (halt) state_next = HALTED;
      HALTED:  if (!halt) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Queued entries count against the budget too, so a response always finds room.
  assign occupancy = {1'b0, in_flight} + {1'b0, q_count};

  always_comb begin
    imem_req = 1'b0;
    if (state == RUN && !flush && occupancy < (CW+1)'(DEPTH)) imem_req = 1'b1;
  end

  assign imem_addr  = word_align(pc_i);
  assign pc_advance = imem_req & imem_gnt;
  assign state_dbg  = state;

  assign drop_hit       = imem_rvalid & (drop != '0);
  assign q_push         = imem_rvalid & ~drop_hit & ~flush;
  assign q_pop          = id_valid & id_ready;
  assign in_flight_next = in_flight + CW'(pc_advance) - CW'(imem_rvalid);

  // Responses to be discarded: everything still outstanding once this cycle settles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop        <= '0;
      fetch_count <= '0;
    end else begin
      if (flush)         drop <= in_flight_next;
      else if (drop_hit) drop <= drop - CW'(1);
      if (q_push) fetch_count <= fetch_count + CNT_W'(1);
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_SIZE)) u_pc_fifo (
    .clk(clk), .rst(rst), .clear(1'b0),
    .push(pc_advance), .pop(imem_rvalid), .din(pc_i), .dout(rsp_pc),
    .full(pf_full), .empty(pf_empty), .count(in_flight)
  );

  assign q_din = '{pc: rsp_pc, instr: imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_queue (
    .clk(clk), .rst(rst), .clear(flush),
    .push(q_push), .pop(q_pop), .din(q_din), .dout(q_head),
    .full(q_full), .empty(q_empty), .count(q_count)
  );

  assign id_valid = ~q_empty;
  assign id_pc    = q_head.pc;
  assign id_instr = q_head.instr;

  always @(posedge clk) begin
    if (rst) begin
      assert (!(q_push && q_full && !q_pop));
      assert (!(imem_rvalid && pf_empty));
      assert (!(pc_advance && pf_full && !imem_rvalid));
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a one-cycle-latency memory model, a PC register model and
// an expected-PC queue checked on every decode pop.
module tb_fetch_unit;
  import fetch_pkg::*;
  localparam int W = WORD_SIZE;

  logic         clk, rst_n, halt, flush, imem_gnt, imem_rvalid, id_ready;
  logic [W-1:0] pc_i, imem_rdata, imem_addr, id_instr, id_pc;
  logic         pc_advance, imem_req, id_valid;
  logic [31:0]  fetch_count;
  fetch_state_t state_dbg;

  int tests  = 0;
  int failed = 0;
  int hs_cnt = 0;
  logic [W-1:0] pc_reg;
  logic [W-1:0] pend_q[$];
  logic [W-1:0] exp_q[$];

  fetch_unit #(.DEPTH(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst_n), .halt(halt), .flush(flush), .pc_i(pc_i),
    .pc_advance(pc_advance), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
    .fetch_count(fetch_count), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, let combinational outputs settle, then observe.
  task automatic step(input logic g, input logic rdy, input logic hlt, input logic fl, input logic resp);
    logic [W-1:0] e;
    @(negedge clk);
    pc_i = pc_reg; imem_gnt = g; id_ready = rdy; halt = hlt; flush = fl;
    if (resp && pend_q.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    if (imem_req && imem_gnt) begin
      pend_q.push_back(imem_addr);
      hs_cnt++;
    end
    if (pc_advance) pc_reg = pc_reg + 32'd4;
    if (id_valid && id_ready) begin
      tests++;
      assert (exp_q.size() > 0) else begin
        failed++;
        $error("FAIL pop_unexpected: observed pc %h expected no pop", id_pc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pop_pc", id_pc, e);
        chk("pop_instr", id_instr, mem_word(e));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; halt = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; id_ready = 1'b0; pc_reg = '0; pc_i = '0;
    #3;
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_adv", pc_advance, 1'b0);
    chk1("rst_id_valid", id_valid, 1'b0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_fetch_count", fetch_count, 32'h0);
    chk1("rst_state_idle", state_dbg == IDLE, 1'b1);

    // Streaming fetch with decode always ready.
    @(negedge clk); rst_n = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1; #1;
    chk1("t1_idle_req", imem_req, 1'b0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    step(1, 1, 0, 0, 1); chk1("t1_c1_req", imem_req, 1'b1); chk("t1_c1_addr", imem_addr, 32'h0);
    chk1("t1_c1_adv", pc_advance, 1'b1);
    step(1, 1, 0, 0, 1); chk1("t1_c2_adv", pc_advance, 1'b1); chk("t1_c2_addr", imem_addr, 32'h4);
    step(1, 1, 0, 0, 1); chk1("t1_c3_valid", id_valid, 1'b1); chk1("t1_c3_credit", imem_req, 1'b0);
    step(1, 1, 0, 0, 1); chk1("t1_c4_adv", pc_advance, 1'b1); chk("t1_c4_addr", imem_addr, 32'h8);
    step(1, 1, 0, 0, 1); chk1("t1_c5_valid", id_valid, 1'b0);
    step(1, 1, 0, 0, 1); chk1("t1_c6_valid", id_valid, 1'b1);
    step(0, 1, 0, 0, 1); chk1("t1_c7_req", imem_req, 1'b1); chk1("t1_c7_adv", pc_advance, 1'b0);
    step(0, 1, 0, 0, 1); chk1("t1_c8_valid", id_valid, 1'b0); chk("t1_count", fetch_count, 32'd4);

    // Decode stalled: credits stop issue after two handshakes.
    hs_cnt = 0;
    exp_q.push_back(32'h10); exp_q.push_back(32'h14); exp_q.push_back(32'h18);
    step(1, 0, 0, 0, 1); chk1("t2_d0_req", imem_req, 1'b1); chk("t2_d0_addr", imem_addr, 32'h10);
    step(1, 0, 0, 0, 1); chk("t2_d1_addr", imem_addr, 32'h14);
    step(1, 0, 0, 0, 1); chk1("t2_d2_req", imem_req, 1'b0); chk1("t2_d2_valid", id_valid, 1'b1);
    step(1, 0, 0, 0, 1); chk1("t2_d3_req", imem_req, 1'b0); chk("t2_hs", hs_cnt, 32'd2);
    step(1, 1, 0, 0, 1); chk1("t2_d4_req", imem_req, 1'b0);
    step(1, 0, 0, 0, 1); chk1("t2_d5_req", imem_req, 1'b1); chk("t2_d5_addr", imem_addr, 32'h18);
    step(1, 0, 0, 0, 1); chk1("t2_d6_req", imem_req, 1'b0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1); chk1("t2_drained", id_valid, 1'b0); chk("t2_count", fetch_count, 32'd7);

    // Flush with two requests outstanding; both responses must vanish.
    exp_q.push_back(32'h100);
    step(1, 1, 0, 0, 0); chk("t3_e0_addr", imem_addr, 32'h1C);
    step(1, 1, 0, 0, 0); chk("t3_e1_addr", imem_addr, 32'h20);
    pc_reg = 32'h100;
    step(1, 1, 0, 1, 0); chk1("t3_flush_req", imem_req, 1'b0); chk1("t3_flush_adv", pc_advance, 1'b0);
    step(0, 1, 0, 0, 1); chk1("t3_e3_valid", id_valid, 1'b0); chk1("t3_e3_req", imem_req, 1'b0);
    step(1, 1, 0, 0, 1); chk1("t3_e4_req", imem_req, 1'b1); chk("t3_e4_addr", imem_addr, 32'h100);
    chk1("t3_e4_valid", id_valid, 1'b0);
    step(0, 1, 0, 0, 1); chk1("t3_e5_valid", id_valid, 1'b0);
    step(0, 1, 0, 0, 1); chk1("t3_e6_valid", id_valid, 1'b1);
    step(0, 1, 0, 0, 0); chk1("t3_drained", id_valid, 1'b0); chk("t3_count", fetch_count, 32'd8);

    // Flush coinciding with a response and an offered grant.
    exp_q.push_back(32'h200);
    step(1, 1, 0, 0, 0); chk("t4_f0_addr", imem_addr, 32'h104);
    step(1, 1, 0, 0, 1); chk("t4_f1_addr", imem_addr, 32'h108);
    pc_reg = 32'h200;
    step(1, 0, 0, 1, 1); chk1("t4_flush_req", imem_req, 1'b0); chk1("t4_flush_adv", pc_advance, 1'b0);
    step(1, 1, 0, 0, 0); chk1("t4_f3_valid", id_valid, 1'b0); chk("t4_f3_addr", imem_addr, 32'h200);
    chk1("t4_f3_req", imem_req, 1'b1);
    step(0, 1, 0, 0, 1); chk1("t4_f4_valid", id_valid, 1'b0);
    step(0, 1, 0, 0, 1); chk1("t4_f5_valid", id_valid, 1'b1);
    step(0, 1, 0, 0, 0); chk1("t4_drained", id_valid, 1'b0); chk("t4_count", fetch_count, 32'd10);

    // Halt with one request outstanding, then resume at the held PC.
    exp_q.push_back(32'h204); exp_q.push_back(32'h208);
    step(1, 0, 0, 0, 0); chk("t5_g0_addr", imem_addr, 32'h204);
    step(0, 0, 1, 0, 0); chk1("t5_g1_adv", pc_advance, 1'b0);
    step(1, 0, 1, 0, 1); chk1("t5_g2_req", imem_req, 1'b0); chk1("t5_halted", state_dbg == HALTED, 1'b1);
    step(1, 1, 1, 0, 1); chk1("t5_g3_valid", id_valid, 1'b1); chk1("t5_g3_req", imem_req, 1'b0);
    step(1, 1, 1, 0, 1); chk1("t5_g4_valid", id_valid, 1'b0); chk1("t5_g4_req", imem_req, 1'b0);
    step(1, 1, 0, 0, 1); chk1("t5_g5_req", imem_req, 1'b0);
    step(1, 1, 0, 0, 1); chk1("t5_g6_req", imem_req, 1'b1); chk("t5_g6_addr", imem_addr, 32'h208);
    chk1("t5_g6_adv", pc_advance, 1'b1);
    step(0, 1, 0, 0, 1); chk1("t5_g7_valid", id_valid, 1'b0);
    step(0, 1, 0, 0, 1); chk1("t5_g8_valid", id_valid, 1'b1);
    step(0, 1, 0, 0, 0); chk1("t5_drained", id_valid, 1'b0); chk("t5_count", fetch_count, 32'd12);

    // Asynchronous reset in the middle of activity.
    step(1, 0, 0, 0, 1); chk("t6_h0_addr", imem_addr, 32'h20C);
    step(1, 0, 0, 0, 1); chk("t6_h1_addr", imem_addr, 32'h210);
    @(negedge clk); #1;
    chk("t6_pre_count", fetch_count, 32'd13);
    chk1("t6_pre_valid", id_valid, 1'b1);
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
    #1;
    chk1("t6_req", imem_req, 1'b0);
    chk1("t6_adv", pc_advance, 1'b0);
    chk1("t6_valid", id_valid, 1'b0);
    chk("t6_instr", id_instr, 32'h0);
    chk("t6_pc", id_pc, 32'h0);
    chk("t6_count", fetch_count, 32'h0);
    chk1("t6_state_idle", state_dbg == IDLE, 1'b1);
    pend_q.delete();
    pc_reg = 32'h300;
    @(negedge clk); pc_i = pc_reg; rst_n = 1'b1; #1;
    chk1("t6_release_idle", state_dbg == IDLE, 1'b1);
    chk1("t6_release_req", imem_req, 1'b0);
    step(0, 1, 0, 0, 0);
    chk1("t6_run_req", imem_req, 1'b1);
    chk("t6_run_addr", imem_addr, 32'h300);
    chk1("t6_run_state", state_dbg == RUN, 1'b1);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
